// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the core MEM stage (priority) and the host/debug port.
// Host starvation is bounded by STARVE_MAX; read data is steered back through a latency-matched tag pipe.
module dmem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          sys_clk_i,
    input  logic          rst_n_i,
    input  logic          core_rd_en_i,
    input  logic          core_wr_en_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    output logic          core_stall_o,
    output logic          core_rvalid_o,
    output logic [DW-1:0] core_rdata_o,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic          host_gnt_o,
    output logic          host_rvalid_o,
    output logic [DW-1:0] host_rdata_o,
    output logic          dm_rd_en_o,
    output logic          dm_wr_en_o,
    output logic [AW-1:0] dm_addr_o,
    output logic [DW-1:0] dm_wdata_o,
    input  logic [DW-1:0] dm_rdata_i
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic              core_req_s;
    logic              core_rd_s;
    logic              host_win_s;
    logic              core_go_s;
    logic              issue_rd_s;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_own_q, tag_own_d;
    logic [DW-1:0]     core_rdata_q, core_rdata_d;
    logic [DW-1:0]     host_rdata_q, host_rdata_d;

    // Grant decision; gated by reset so no strobe leaks out while the block is held in reset.
    always_comb begin
        core_req_s = core_rd_en_i | core_wr_en_i;
        core_rd_s  = core_rd_en_i & ~core_wr_en_i;
        host_win_s = rst_n_i & host_req_i & (~core_req_s | (wait_cnt_q == STARVE_LIM));
        core_go_s  = rst_n_i & core_req_s & ~host_win_s;
        issue_rd_s = (host_win_s & ~host_we_i) | (core_go_s & core_rd_s);
    end

    assign host_gnt_o   = host_win_s;
    assign core_stall_o = rst_n_i & core_req_s & host_win_s;

    // Memory command mux: the winner drives the port in the grant cycle.
    always_comb begin
        dm_rd_en_o = 1'b0;
        dm_wr_en_o = 1'b0;
        dm_addr_o  = {AW{1'b0}};
        dm_wdata_o = {DW{1'b0}};
        if (host_win_s) begin
            dm_rd_en_o = ~host_we_i;
            dm_wr_en_o = host_we_i;
            dm_addr_o  = host_addr_i;
            dm_wdata_o = host_wdata_i;
        end else if (core_go_s) begin
            dm_rd_en_o = core_rd_s;
            dm_wr_en_o = core_wr_en_i;
            dm_addr_o  = core_addr_i;
            dm_wdata_o = core_wdata_i;
        end else begin
            dm_rd_en_o = 1'b0;
            dm_wr_en_o = 1'b0;
        end
    end

    // Starvation counter next state: saturating count of refused host cycles.
    always_comb begin
        wait_cnt_d = {CW{1'b0}};
        if (host_req_i & ~host_win_s) begin
            if (wait_cnt_q == STARVE_LIM) begin
                wait_cnt_d = STARVE_LIM;
            end else begin
                wait_cnt_d = wait_cnt_q + CW'(1'b1);
            end
        end else begin
            wait_cnt_d = {CW{1'b0}};
        end
    end

    // Tag pipe next state; owner bit 1 marks a host read.
    always_comb begin
        tag_vld_d    = {RD_LAT{1'b0}};
        tag_own_d    = {RD_LAT{1'b0}};
        tag_vld_d[0] = issue_rd_s;
        tag_own_d[0] = host_win_s;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
    end

    assign core_rvalid_o = tag_vld_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
    assign host_rvalid_o = tag_vld_q[RD_LAT-1] &  tag_own_q[RD_LAT-1];

    // Return data: pass memory data through on rvalid, otherwise hold the last value per owner.
    always_comb begin
        core_rdata_d = core_rdata_q;
        host_rdata_d = host_rdata_q;
        if (core_rvalid_o) begin
            core_rdata_d = dm_rdata_i;
        end else begin
            core_rdata_d = core_rdata_q;
        end
        if (host_rvalid_o) begin
            host_rdata_d = dm_rdata_i;
        end else begin
            host_rdata_d = host_rdata_q;
        end
    end

    assign core_rdata_o = core_rdata_d;
    assign host_rdata_o = host_rdata_d;

    // State registers; reset drops any in-flight read tags.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt_q   <= {CW{1'b0}};
            tag_vld_q    <= {RD_LAT{1'b0}};
            tag_own_q    <= {RD_LAT{1'b0}};
            core_rdata_q <= {DW{1'b0}};
            host_rdata_q <= {DW{1'b0}};
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            tag_vld_q    <= tag_vld_d;
            tag_own_q    <= tag_own_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: one instance at RD_LAT=1 and one at RD_LAT=2 share stimulus,
// each with its own behavioural memory; monitors pop expected read returns on every rvalid.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_rd, core_wr, host_req, host_we;
    logic [31:0] core_addr, core_wdata, host_addr, host_wdata;

    logic        c_stall1, c_rv1, h_gnt1, h_rv1, dm_rd1, dm_wr1;
    logic [31:0] c_rd1, h_rd1, dm_addr1, dm_wd1, dm_rdata1;
    logic        c_stall2, c_rv2, h_gnt2, h_rv2, dm_rd2, dm_wr2;
    logic [31:0] c_rd2, h_rd2, dm_addr2, dm_wd2, dm_rdata2;

    logic [31:0] mem1 [0:63];
    logic [31:0] mem2 [0:63];
    logic [31:0] rp1, rp2a, rp2b;

    int checks = 0;
    int errors = 0;
    logic [32:0] q1 [$];
    logic [32:0] q2 [$];

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .sys_clk_i(clk), .rst_n_i(rst_n),
        .core_rd_en_i(core_rd), .core_wr_en_i(core_wr), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_stall_o(c_stall1), .core_rvalid_o(c_rv1), .core_rdata_o(c_rd1),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_gnt_o(h_gnt1), .host_rvalid_o(h_rv1), .host_rdata_o(h_rd1),
        .dm_rd_en_o(dm_rd1), .dm_wr_en_o(dm_wr1), .dm_addr_o(dm_addr1), .dm_wdata_o(dm_wd1),
        .dm_rdata_i(dm_rdata1)
    );

    dmem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(2), .STARVE_MAX(4)) u_dut2 (
        .sys_clk_i(clk), .rst_n_i(rst_n),
        .core_rd_en_i(core_rd), .core_wr_en_i(core_wr), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_stall_o(c_stall2), .core_rvalid_o(c_rv2), .core_rdata_o(c_rd2),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_gnt_o(h_gnt2), .host_rvalid_o(h_rv2), .host_rdata_o(h_rd2),
        .dm_rd_en_o(dm_rd2), .dm_wr_en_o(dm_wr2), .dm_addr_o(dm_addr2), .dm_wdata_o(dm_wd2),
        .dm_rdata_i(dm_rdata2)
    );

    // Behavioural memories with 1- and 2-cycle read latency
    always @(posedge clk) begin
        if (dm_wr1) mem1[dm_addr1[7:2]] <= dm_wd1;
        rp1 <= mem1[dm_addr1[7:2]];
        if (dm_wr2) mem2[dm_addr2[7:2]] <= dm_wd2;
        rp2a <= mem2[dm_addr2[7:2]];
        rp2b <= rp2a;
    end
    assign dm_rdata1 = rp1;
    assign dm_rdata2 = rp2b;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic own, input logic [31:0] d);
        q1.push_back({own, d});
        q2.push_back({own, d});
    endtask

    task automatic mon_check(input int id, input logic cv, input logic hv,
                             input logic [31:0] cd, input logic [31:0] hd);
        logic [32:0] e;
        if (cv === 1'b1 && hv === 1'b1) begin
            chk($sformatf("both_rvalid_dut%0d", id), 64'd1, 64'd0);
        end else if (cv === 1'b1 || hv === 1'b1) begin
            if ((id == 1 && q1.size() == 0) || (id == 2 && q2.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL spurious_rvalid dut%0d actual core=%0b host=%0b required none", id, cv, hv);
            end else begin
                if (id == 1) e = q1.pop_front();
                else         e = q2.pop_front();
                chk($sformatf("rvalid_owner_dut%0d", id), 64'(hv), 64'(e[32]));
                chk($sformatf("rdata_dut%0d", id), 64'(hv ? hd : cd), 64'(e[31:0]));
            end
        end
    endtask

    always @(negedge clk) mon_check(1, c_rv1, h_rv1, c_rd1, h_rd1);
    always @(negedge clk) mon_check(2, c_rv2, h_rv2, c_rd2, h_rd2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic hr, input logic hw, input logic [31:0] ha, input logic [31:0] hd);
        core_rd = cr; core_wr = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 64'({c_stall1, c_rv1, h_gnt1, h_rv1, dm_rd1, dm_wr1}), 64'd0);
        chk("rst_rdata", {c_rd1, h_rd1}, 64'd0);
        chk("rst_dm", {dm_addr1, dm_wd1}, 64'd0);
        chk("rst_wait", 64'(u_dut1.wait_cnt_q), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("idle", 64'({c_stall1, h_gnt1, dm_rd1, dm_wr1, c_rv2, h_rv2, dm_rd2, dm_wr2}), 64'd0);
        end

        // Preload through the host port while the core is idle
        step(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h00, 32'h0000_1111);
        @(negedge clk); chk("preload0_gnt", 64'(h_gnt1), 64'd1);
        step(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h04, 32'h4444_0004);
        step(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        step(); idle();

        // Core read of 0x10
        step(); drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("core_rd_cmd", 64'({dm_rd1, dm_wr1, c_stall1}), 64'b100);
        chk("core_rd_addr", 64'(dm_addr1), 64'h10);
        push(1'b0, 32'hDEAD_BEEF);
        step(); idle();
        @(negedge clk);
        chk("core_rvalid_lat1", 64'({c_rv1, c_stall1}), 64'b10);

        // Host write 0x20 then read back
        step(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        @(negedge clk);
        chk("host_wr_gnt", 64'({h_gnt1, dm_wr1, dm_rd1}), 64'b110);
        chk("host_wr_cmd", {dm_addr1, dm_wd1}, 64'h0000_0020_1234_5678);
        step(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        chk("host_rd_gnt", 64'({h_gnt1, dm_rd1}), 64'b11);
        push(1'b1, 32'h1234_5678);
        step(); idle();
        @(negedge clk);
        chk("host_rvalid_lat1", 64'(h_rv1), 64'd1);
        step();
        @(negedge clk);
        chk("rdata_hold", {c_rd1, h_rd1}, 64'hDEAD_BEEF_1234_5678);

        // Starvation: core reads every cycle, host read of 0x0 pending from cycle 0
        for (int c = 0; c < 6; c++) begin
            step();
            drive(1'b1, 1'b0, 32'h10, 32'h0, (c <= 4), 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            if (c < 4) begin
                chk($sformatf("starve_c%0d_gnt_stall", c), 64'({h_gnt1, c_stall1}), 64'b00);
                chk($sformatf("starve_c%0d_wait", c), 64'(u_dut1.wait_cnt_q), 64'(c));
                push(1'b0, 32'hDEAD_BEEF);
            end else if (c == 4) begin
                chk("starve_c4_gnt_stall", 64'({h_gnt1, c_stall1, h_gnt2, c_stall2}), 64'b1111);
                chk("starve_c4_addr", 64'(dm_addr1), 64'h0);
                push(1'b1, 32'h0000_1111);
            end else begin
                chk("starve_c5_gnt_stall", 64'({h_gnt1, c_stall1, dm_rd1}), 64'b001);
                chk("starve_c5_wait", 64'(u_dut1.wait_cnt_q), 64'd0);
                push(1'b0, 32'hDEAD_BEEF);
            end
        end
        step(); idle();
        repeat (3) step();

        // Interleaved reads, checked for exact timing on the RD_LAT=2 instance
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(1'b0, 32'h0000_1111);
        step(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        chk("inter_host_gnt", 64'(h_gnt2), 64'd1);
        push(1'b1, 32'h4444_0004);
        step(); idle();
        @(negedge clk);
        chk("inter_t2_rvalid", 64'({c_rv2, h_rv2}), 64'b10);
        step();
        @(negedge clk);
        chk("inter_t3_rvalid", 64'({c_rv2, h_rv2}), 64'b01);
        repeat (3) step();

        // Reset one cycle after a core read issues, with a refused host request pending
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        chk("midrst_issue", 64'({dm_rd1, h_gnt1, c_stall1}), 64'b100);
        step(); idle(); rst_n = 1'b0;
        step(); step();
        @(negedge clk); rst_n = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("midrst_wait", 64'({u_dut1.wait_cnt_q, u_dut2.wait_cnt_q}), 64'd0);

        // Simultaneous read+write is a write with no return
        step(); drive(1'b1, 1'b1, 32'h30, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("illegal_cmd", 64'({dm_rd1, dm_wr1, dm_rd2, dm_wr2}), 64'b0101);
        step(); idle();
        @(negedge clk);
        chk("illegal_no_rvalid", 64'({c_rv1, c_rv2}), 64'd0);
        step(); drive(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        push(1'b0, 32'h5555_AAAA);
        step(); idle();
        repeat (4) step();
        @(negedge clk);

        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core MEM stage and the top-level host/debug port.
- The core has priority. The host is guaranteed service within STARVE_MAX cycles.
- When the host wins a cycle, the block stalls the core. Read data is routed back to the correct owner using a latency-matched tag pipeline.
- Sits between the MEM stage / top debug interface and data_memory.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, data-memory read latency in cycles; legal range 1..4.
- STARVE_MAX, 4, maximum cycles a pending host request may be refused before it must be granted; legal values ≥1.

Ports:
- sys_clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- core_rd_en_i  in  1  MEM-stage load request.
- core_wr_en_i  in  1  MEM-stage store request.
- core_addr_i  in  AW  core byte address.
- core_wdata_i  in  DW  core store data.
- core_stall_o  out  1  core access refused this cycle; MEM stage must hold its request.
- core_rvalid_o  out  1  core load data valid.
- core_rdata_o  out  DW  core load data.
- host_req_i  in  1  host request.
- host_we_i  in  1  host write (1) or read (0).
- host_addr_i  in  AW  host address.
- host_wdata_i  in  DW  host write data.
- host_gnt_o  out  1  host access issued this cycle.
- host_rvalid_o  out  1  host read data valid.
- host_rdata_o  out  DW  host read data.
- dm_rd_en_o  out  1  memory read strobe.
- dm_wr_en_o  out  1  memory write strobe.
- dm_addr_o  out  AW  memory address.
- dm_wdata_o  out  DW  memory write data.
- dm_rdata_i  in  DW  memory read data, valid RD_LAT cycles after dm_rd_en_o.

Behaviour:
- **Reset (async assert, sync release):**
  - All outputs are 0; core_rdata_o and host_rdata_o are 0.
  - Starvation counter is 0.
  - Tag pipeline is cleared. In-flight reads are discarded, and no rvalid is produced after reset release for a read issued before reset.
- **Requests:**
  - core_req = core_rd_en_i | core_wr_en_i.
  - Both core_rd_en_i and core_wr_en_i high means write; the read is ignored and no core_rvalid_o is produced.
- **Grant, decided combinationally each cycle:**
  - host_win = host_req_i & (~core_req | wait_cnt == STARVE_MAX).
  - core_go = core_req & ~host_win.
  - host_gnt_o = host_win.
  - core_stall_o = core_req & host_win.
- **Memory command:**
  - Memory signals are driven from the winning requester.
  - With no winner: dm_rd_en_o = dm_wr_en_o = 0, and dm_addr_o / dm_wdata_o = 0.
  - The command is issued in the same cycle as the grant (zero added latency).
- **Starvation counter wait_cnt** (width clog2(STARVE_MAX+1)):
  - Increments when host_req_i & ~host_gnt_o.
  - Clears when host_gnt_o or when ~host_req_i.
  - Saturates at STARVE_MAX.
- **Host handshake:**
  - The host holds req, we, addr and wdata stable until host_gnt_o.
  - host_gnt_o is high for exactly one cycle per access.
  - Back-to-back host requests are allowed; wait_cnt restarts from 0 after each grant, so the core regains priority.
- **Core stall:**
  - The MEM stage holds its inputs while core_stall_o = 1.
  - The access completes in the first non-stalled cycle.
  - Maximum core stall is 1 consecutive cycle per host grant.
- **Read return:**
  - Tag pipeline of depth RD_LAT carries {valid, owner} for each issued read.
  - At the pipeline output, the matching rvalid pulses for 1 cycle. The matching rdata output equals dm_rdata_i in that cycle, then holds that value until that owner's next rvalid.
  - Writes produce no rvalid.
  - Reads from both owners may be in flight simultaneously; return order equals issue order.
- **Idle:** no requests means no memory strobes and wait_cnt = 0.

Test Plan:
- **Reset defaults and idle:** reset, then idle 5 cycles → all outputs 0, dm strobes 0, no rvalid.
- **Core read:** core_rd_en_i=1, addr=0x10, memory word 0x10 = 0xDEADBEEF, RD_LAT=1 → dm_rd_en_o=1 same cycle; next cycle core_rvalid_o=1, core_rdata_o=0xDEADBEEF; core_stall_o=0 throughout.
- **Host write while core idle:** host_req_i=1, we=1, addr=0x20, wdata=0x12345678 → host_gnt_o=1 same cycle, dm_wr_en_o=1, dm_addr_o=0x20; then a host read of 0x20 → host_rvalid_o after 1 cycle with 0x12345678.
- **Starvation with continuous core traffic:** host read pending from cycle 0, STARVE_MAX=4 →
  - host refused cycles 0–3;
  - cycle 4: host_gnt_o=1 and core_stall_o=1;
  - cycle 5: core proceeds, wait_cnt=0.
- **Interleaved reads, RD_LAT=2:** core read 0x0 at cycle t, host read 0x4 at t+1 → core_rvalid_o at t+2 with mem[0x0], host_rvalid_o at t+3 with mem[0x4]; no cross-routing.
- **Reset mid-operation and illegal request:**
  - Reset asserted one cycle after a core read issues → no core_rvalid_o after release; wait_cnt is 0 after release.
  - core_rd_en_i = core_wr_en_i = 1 → dm_wr_en_o=1, dm_rd_en_o=0, no core_rvalid_o.
